// File: rtl/data_memory_responder.sv
// Data-memory responder: one load/store at a time, a fixed wait before the
// array access, and a held response until the initiator consumes it.
module data_memory_responder #(
  parameter int WORDSIZE = 64,
  parameter int SIZE     = 32,
  parameter int ADDR_W   = 5,
  parameter int LATENCY  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [WORDSIZE-1:0] req_wdata,
  output logic                req_ready,
  output logic                resp_valid,
  output logic [WORDSIZE-1:0] resp_rdata,
  output logic                resp_error,
  input  logic                resp_ready
);

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

  localparam logic [3:0]      LAT_CNT  = 4'(LATENCY);
  localparam logic [ADDR_W:0] SIZE_EXT = (ADDR_W + 1)'(SIZE);

  state_t                state;
  logic [3:0]            count;
  logic                  write_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [WORDSIZE-1:0]   wdata_q;
  logic [WORDSIZE-1:0]   mem [SIZE];
  logic                  in_range;

  // Compare with one extra bit so upper addresses are rejected, never wrapped.
  assign in_range   = ({1'b0, addr_q} < SIZE_EXT);
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESPOND);

  // WAIT always holds LATENCY+1 cycles: the last one performs the array access,
  // so the response appears LATENCY+1 edges after acceptance, even for LATENCY=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
      for (int i = 0; i < SIZE; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            count   <= LAT_CNT;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (count == 4'd0) begin
            state <= RESPOND;
            if (!in_range) begin
              resp_rdata <= '0;
              resp_error <= 1'b1;
            end else if (write_q) begin
              mem[addr_q] <= wdata_q;
              resp_rdata  <= wdata_q;
              resp_error  <= 1'b0;
            end else begin
              resp_rdata <= mem[addr_q];
              resp_error <= 1'b0;
            end
          end else begin
            count <= count - 4'd1;
          end
        end
        RESPOND: begin
          if (resp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A response held under backpressure must not change underneath the initiator.
  a_resp_stable: assert property (@(posedge clk) disable iff (rst)
    (resp_valid && !resp_ready) |=> ($stable(resp_rdata) && $stable(resp_error)));

  a_one_side: assert property (@(posedge clk) disable iff (rst)
    !(req_ready && resp_valid));

endmodule
